// File: rtl/unpack_pipe.sv
// unpack_pipe: splits NOPS IEEE-754 operands (double or single) into sign, exponent, significand,
// leading-zero count and class flags over a 2-stage pipeline. Optional feature macro: UNPACK_NAN_PROP_EN.
module unpack_pipe #(
    parameter int NOPS   = 2,
    parameter int IN_REG = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NOPS*64-1:0] op_in,
    input  logic               db,
    input  logic               normal,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NOPS-1:0]    s,
    output logic [NOPS*11-1:0] e,
    output logic [NOPS*6-1:0]  lz,
    output logic [NOPS*53-1:0] f,
    output logic [NOPS*4-1:0]  fl,
    output logic [52:0]        nan
);
    localparam logic [52:0] QNAN = {2'b11, 51'd0};

    // Handshake: a transfer happens on a rising edge where valid and ready are both high; a stage
    // loads when it is empty or its contents move on in the same cycle (ready never waits on valid).
    logic               v1, v2;
    logic               rdy1, rdy2;
    logic               src_valid, src_db, src_normal;
    logic [NOPS*64-1:0] src_op;

    assign rdy2      = ~v2 | out_ready;
    assign rdy1      = ~v1 | rdy2;
    assign out_valid = v2;

    if (IN_REG != 0) begin : g_in_reg
        logic               v0, db0, normal0;
        logic [NOPS*64-1:0] op0;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0      <= 1'b0;
                op0     <= '0;
                db0     <= 1'b0;
                normal0 <= 1'b0;
            end else if (~v0 | rdy1) begin
                v0 <= in_valid;
                if (in_valid) begin
                    op0     <= op_in;
                    db0     <= db;
                    normal0 <= normal;
                end
            end
        end
        assign in_ready   = ~v0 | rdy1;
        assign src_valid  = v0;
        assign src_op     = op0;
        assign src_db     = db0;
        assign src_normal = normal0;
    end else begin : g_no_in_reg
        assign in_ready   = rdy1;
        assign src_valid  = in_valid;
        assign src_op     = op_in;
        assign src_db     = db;
        assign src_normal = normal;
    end

    // Stage 1 decode: single-format fractions are left-aligned so both formats share one layout.
    logic [NOPS-1:0]    d_s;
    logic [NOPS*11-1:0] d_e;
    logic [NOPS*53-1:0] d_f;
    logic [NOPS*4-1:0]  d_fl;
    logic [52:0]        d_nan;

    for (genvar k = 0; k < NOPS; k++) begin : g_dec
        logic [63:0] w;
        logic [10:0] ef;
        logic [51:0] frac;
        logic        emax, enz, fnz;
        assign w    = src_op[64*k +: 64];
        assign ef   = src_db ? w[62:52] : {3'b000, w[62:55]};
        assign frac = src_db ? w[51:0] : {w[54:32], 29'd0};
        assign emax = src_db ? (w[62:52] == 11'h7FF) : (w[62:55] == 8'hFF);
        assign enz  = (ef != 11'd0);
        assign fnz  = (frac != 52'd0);
        assign d_s[k]          = w[63];
        assign d_e[11*k +: 11] = enz ? ef : {10'd0, fnz};
        assign d_f[53*k +: 53] = {enz, frac};
        assign d_fl[4*k +: 4]  = {~enz & ~fnz, emax & ~fnz, emax & fnz, emax & fnz & ~frac[51]};
    end

`ifdef UNPACK_NAN_PROP_EN
    // Scan from the top index down so the lowest-index NaN wins.
    always_comb begin
        d_nan = QNAN;
        for (int k = NOPS - 1; k >= 0; k--) begin
            if (d_fl[4*k+1]) d_nan = {2'b11, d_f[53*k +: 51]};
        end
    end
`else
    assign d_nan = QNAN;
`endif

    logic [NOPS-1:0]    s1_s;
    logic [NOPS*11-1:0] s1_e;
    logic [NOPS*53-1:0] s1_f;
    logic [NOPS*4-1:0]  s1_fl;
    logic [52:0]        s1_nan;
    logic               s1_normal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1_s      <= '0;
            s1_e      <= '0;
            s1_f      <= '0;
            s1_fl     <= '0;
            s1_nan    <= '0;
            s1_normal <= 1'b0;
        end else if (rdy1) begin
            v1 <= src_valid;
            if (src_valid) begin
                s1_s      <= d_s;
                s1_e      <= d_e;
                s1_f      <= d_f;
                s1_fl     <= d_fl;
                s1_nan    <= d_nan;
                s1_normal <= src_normal;
            end
        end
    end

    // Leading-zero count over 53 bits; an all-zero input reports 53.
    function automatic logic [5:0] lzc(input logic [52:0] x);
        lzc = 6'd53;
        for (int i = 0; i <= 52; i++) begin
            if (x[i]) lzc = 6'(52 - i);
        end
    endfunction

    logic [NOPS*6-1:0]  d_lz;
    logic [NOPS*53-1:0] d_fn;

    for (genvar k = 0; k < NOPS; k++) begin : g_norm
        logic [52:0] fk;
        logic [5:0]  lzk;
        assign fk  = s1_f[53*k +: 53];
        assign lzk = lzc(fk);
        assign d_lz[6*k +: 6]   = lzk;
        assign d_fn[53*k +: 53] = s1_normal ? (fk << lzk) : fk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            s   <= '0;
            e   <= '0;
            lz  <= '0;
            f   <= '0;
            fl  <= '0;
            nan <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                s   <= s1_s;
                e   <= s1_e;
                lz  <= d_lz;
                f   <= d_fn;
                fl  <= s1_fl;
                nan <= s1_nan;
            end
        end
    end
endmodule

// File: tb/tb_unpack_pipe.sv
// tb_unpack_pipe: directed and randomized checks of unpack_pipe against an arithmetic reference model.
module tb_unpack_pipe;
    localparam int NOPS = 2;
    localparam int W = NOPS * 75 + 53;
    localparam logic [52:0] QNAN = {2'b11, 51'd0};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NOPS*64-1:0] op_in = '0;
    logic               db = 1'b0;
    logic               normal = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [NOPS-1:0]    s;
    logic [NOPS*11-1:0] e;
    logic [NOPS*6-1:0]  lz;
    logic [NOPS*53-1:0] f;
    logic [NOPS*4-1:0]  fl;
    logic [52:0]        nan;
    logic [W-1:0]       act;

    int n_cmp = 0;
    int n_bad = 0;
    int delivered = 0;
    logic [W-1:0] exp_q[$];
    logic         held_v = 1'b0;
    logic [W-1:0] held = '0;

    assign act = {s, e, lz, f, fl, nan};

    always #5 clk = ~clk;

    unpack_pipe #(.NOPS(NOPS), .IN_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_in(op_in), .db(db), .normal(normal), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .e(e), .lz(lz), .f(f), .fl(fl), .nan(nan)
    );

    // Reference model: fields by arithmetic, normalisation by repeated doubling.
    function automatic logic [W-1:0] model(input logic [NOPS*64-1:0] op, input logic d, input logic n);
        logic [NOPS-1:0]    ms;
        logic [NOPS*11-1:0] me;
        logic [NOPS*6-1:0]  ml;
        logic [NOPS*53-1:0] mf;
        logic [NOPS*4-1:0]  mfl;
        logic [52:0]        mnan;
        logic [63:0]        w;
        longint unsigned    expo, emax, frac, sig, t;
        int                 cnt;
        logic               is_nan;
`ifdef UNPACK_NAN_PROP_EN
        bit                 found;
        found = 1'b0;
`endif
        mnan = QNAN;
        for (int k = 0; k < NOPS; k++) begin
            w = op[64*k +: 64];
            if (d) begin
                expo = 64'(w[62:52]);
                emax = 2047;
                frac = 64'(w[51:0]);
            end else begin
                expo = 64'(w[62:55]);
                emax = 255;
                frac = 64'(w[54:32]) << 29;
            end
            sig = ((expo != 0) ? (64'd1 << 52) : 64'd0) + frac;
            t = sig;
            cnt = 0;
            if (t == 0) cnt = 53;
            else begin
                while (t < (64'd1 << 52)) begin
                    t = t * 2;
                    cnt++;
                end
            end
            is_nan = (expo == emax) && (frac != 0);
            ms[k] = w[63];
            me[11*k +: 11] = 11'((expo != 0) ? expo : ((frac != 0) ? 64'd1 : 64'd0));
            ml[6*k +: 6] = 6'(cnt);
            mf[53*k +: 53] = 53'(n ? t : sig);
            mfl[4*k +: 4] = {(expo == 0) && (frac == 0), (expo == emax) && (frac == 0), is_nan,
                             is_nan && (frac < (64'd1 << 51))};
`ifdef UNPACK_NAN_PROP_EN
            if (is_nan && !found) begin
                mnan = 53'((64'd3 << 51) + (frac % (64'd1 << 51)));
                found = 1'b1;
            end
`endif
        end
        return {ms, me, ml, mf, mfl, mnan};
    endfunction

    function automatic logic [63:0] rand_op(input logic d);
        logic [63:0] w;
        int cls;
        w = {$urandom, $urandom};
        cls = $urandom_range(0, 5);
        if (d) begin
            case (cls)
                1: w[62:0] = '0;
                2: w[62:0] = {11'h7FF, 52'd0};
                3: w[62:51] = 12'hFFF;
                4: begin w[62:51] = 12'hFFE; w[0] = 1'b1; end
                5: w[62:52] = '0;
                default: ;
            endcase
        end else begin
            case (cls)
                1: w[62:32] = '0;
                2: w[62:32] = {8'hFF, 23'd0};
                3: w[62:54] = 9'h1FF;
                4: begin w[62:54] = 9'h1FE; w[32] = 1'b1; end
                5: w[62:55] = '0;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic new_txn();
        db = 1'($urandom_range(0, 1));
        normal = 1'($urandom_range(0, 1));
        for (int k = 0; k < NOPS; k++) op_in[64*k +: 64] = rand_op(db);
    endtask

    // One clock: sample at negedge (scoreboard + stall stability), then step past the next posedge.
    task automatic tick(output logic acc);
        logic [W-1:0] want;
        @(negedge clk);
        acc = in_valid & in_ready;
        if (held_v) begin
            n_cmp++;
            if ({out_valid, act} !== {1'b1, held}) begin
                n_bad++;
                $display("FAIL stall_hold: got valid=%b %h want valid=1 %h", out_valid, act, held);
            end
        end
        held_v = out_valid & ~out_ready;
        held = act;
        if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_extra: got %h want no result", act);
            end else begin
                want = exp_q.pop_front();
                delivered++;
                if (act !== want) begin
                    n_bad++;
                    $display("FAIL scoreboard_data: got %h want %h", act, want);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single isolated transaction; returns the number of edges until out_valid, positioned at a negedge.
    task automatic run_one(input logic [NOPS*64-1:0] op, input logic d, input logic n, output int lat);
        op_in = op;
        db = d;
        normal = n;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (act !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", act); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_fmt();
        int lat;
        run_one({2{64'h3F8F_0000_0000_0000}}, 1'b0, 1'b1, lat);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", lat); end
        n_cmp++;
        if ({s, e, lz} !== {2'b00, 11'h07F, 11'h07F, 12'd0}) begin
            n_bad++; $display("FAIL single_s_e_lz: got %h want %h", {s, e, lz}, {2'b00, 11'h07F, 11'h07F, 12'd0});
        end
        n_cmp++;
        if (f !== {2{53'h11_E000_0000_0000}}) begin
            n_bad++; $display("FAIL single_f: got %h want %h", f, {2{53'h11_E000_0000_0000}});
        end
        n_cmp++;
        if ({fl, nan} !== {8'h00, QNAN}) begin
            n_bad++; $display("FAIL single_fl_nan: got %h want %h", {fl, nan}, {8'h00, QNAN});
        end
    endtask

    task automatic test_denormal();
        int lat;
        run_one({2{64'h0000_0000_0000_0001}}, 1'b1, 1'b1, lat);
        n_cmp++;
        if (e[10:0] !== 11'd1 || lz[5:0] !== 6'd52) begin
            n_bad++; $display("FAIL denorm_e_lz: got e=%h lz=%0d want e=1 lz=52", e[10:0], lz[5:0]);
        end
        n_cmp++;
        if (f[52:0] !== 53'h10_0000_0000_0000 || fl[3:0] !== 4'b0000) begin
            n_bad++; $display("FAIL denorm_f_fl: got f=%h fl=%b want f=10000000000000 fl=0000", f[52:0], fl[3:0]);
        end
    endtask

    task automatic test_nan();
        int lat;
        logic [52:0] want_nan;
`ifdef UNPACK_NAN_PROP_EN
        want_nan = 53'h18_0000_0000_0001;
`else
        want_nan = 53'h18_0000_0000_0000;
`endif
        run_one({64'h7FF8_0000_0000_0000, 64'h7FF0_0000_0000_0001}, 1'b1, 1'b1, lat);
        n_cmp++;
        if (fl !== 8'b0010_0011) begin n_bad++; $display("FAIL nan_flags: got %b want 00100011", fl); end
        n_cmp++;
        if (nan !== want_nan) begin n_bad++; $display("FAIL nan_value: got %h want %h", nan, want_nan); end
    endtask

    task automatic test_zero_inf();
        int lat;
        run_one({64'hFFF0_0000_0000_0000, 64'h0000_0000_0000_0000}, 1'b1, 1'b1, lat);
        n_cmp++;
        if (fl[3:0] !== 4'b1000 || lz[5:0] !== 6'd53 || f[52:0] !== 53'd0) begin
            n_bad++; $display("FAIL zero_op: got fl=%b lz=%0d f=%h want fl=1000 lz=53 f=0", fl[3:0], lz[5:0], f[52:0]);
        end
        n_cmp++;
        if (s[1] !== 1'b1 || fl[7:4] !== 4'b0100 || e[21:11] !== 11'h7FF) begin
            n_bad++; $display("FAIL inf_op: got s=%b fl=%b e=%h want s=1 fl=0100 e=7ff", s[1], fl[7:4], e[21:11]);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int sent, c;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        held_v = 1'b0;
        delivered = 0;
        sent = 0;
        c = 0;
        new_txn();
        while ((sent < 10 || exp_q.size() != 0) && c < 80) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid = (sent < 10);
            tick(acc);
            if (c >= 4 && c <= 7) begin
                n_cmp++;
                if (acc !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_ready: cycle %0d got accept=%b want 0", c, acc); end
            end
            if (acc) begin
                exp_q.push_back(model(op_in, db, normal));
                sent++;
                new_txn();
            end
            c++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (delivered !== 10 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_delivered: got %0d pending %0d want 10 pending 0", delivered, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic acc;
        int sent, c;
        sent = 0;
        c = 0;
        delivered = 0;
        in_valid = 1'b0;
        while ((sent < 300 || exp_q.size() != 0) && c < 6000) begin
            if (!in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
                new_txn();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) begin
                exp_q.push_back(model(op_in, db, normal));
                sent++;
                in_valid = 1'b0;
            end
            c++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (delivered !== 300 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL random_delivered: got %0d pending %0d want 300 pending 0", delivered, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            new_txn();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_async: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        n_cmp++;
        if (act !== '0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", act); end
        exp_q.delete();
        held_v = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got stale out_valid want none"); end
    endtask

    initial begin
        test_reset();
        test_single_fmt();
        test_denormal();
        test_nan();
        test_zero_inf();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/unpack_pipe.md
UNPACK_PIPE -- requirements
Module: unpack_pipe

Interface
REQ-001 Parameter: NOPS, default 2, number of operands unpacked per transaction (legal 1..4).
REQ-002 Parameter: IN_REG, default 0, 1 adds an input register stage (latency +1).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: in_valid  input  1  transaction present on op_in/db/normal.
REQ-006 Port: in_ready  output  1  block accepts the transaction this cycle.
REQ-007 Port: op_in  input  NOPS*64  packed operands; operand k in bits [64k+63:64k].
REQ-008 Port: db  input  1  1 = double format, 0 = single format in bits [63:32] of each operand.
REQ-009 Port: normal  input  1  1 = fraction output left-normalised by lz.
REQ-010 Port: out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 Port: s  output  NOPS  sign per operand.
REQ-012 Port: e  output  NOPS*11  biased exponent per operand, zero-extended for single.
REQ-013 Port: lz  output  NOPS*6  leading-zero count of f before normalisation.
REQ-014 Port: f  output  NOPS*53  significand {hidden, fraction, zero pad}.
REQ-015 Port: fl  output  NOPS*4  flags {zero, inf, nan, snan}.
REQ-016 Port: nan  output  53  significand of the NaN result for the transaction.

Function
REQ-017 Double: sign 63, exponent 62:52, fraction 51:0; single: sign 63, exponent 62:55, fraction 54:32, fraction left-aligned into f[51:29].
REQ-018 Hidden bit = 1 iff exponent field nonzero; denormal (field 0, fraction nonzero) reports e = 1.
REQ-019 Flags: zero = exp 0 & frac 0; inf = exp all-ones & frac 0; nan = exp all-ones & frac nonzero; snan = nan & fraction MSB 0.
REQ-020 lz = leading zeros of f[52:0], range 0..53; zero operand reports lz = 53 and f = 0.
REQ-021 normal = 1: f shifted left by lz; normal = 0: f unshifted; lz reported in both cases.
REQ-022 Pipeline: stage 1 registers field extraction and classification; stage 2 registers lz and shift; latency 2 cycles (3 with IN_REG=1) with out_ready held 1.
REQ-023 A stage advances when its successor is empty or advancing; in_ready = ~v1 | ~v2 | out_ready (first stage).
REQ-024 out_valid high with out_ready low: all outputs hold stable until accepted; no transaction is dropped or duplicated.
REQ-025 Full pipeline with out_ready high sustains one transaction per cycle.
REQ-026 db and normal are captured with op_in and travel with the transaction.

Reset
REQ-027 rst_n low clears all stage valid bits immediately; out_valid = 0, s/e/lz/f/fl/nan = 0.
REQ-028 in_ready = 1 during and after reset; reset mid-transaction discards all in-flight transactions.

Configuration
REQ-029 Macro UNPACK_NAN_PROP_EN defined: nan = {1, fraction[50:0] of lowest-index NaN operand with quiet bit forced 1} (single: fraction aligned per REQ-017); no NaN operand: default quiet NaN.
REQ-030 Macro UNPACK_NAN_PROP_EN undefined: nan = default quiet NaN {2'b11, 51'b0} whenever out_valid, no selection logic built.

Verification
REQ-031 NOPS=2, db=0, normal=1, both operands 64'h3F8F_0000_0000_0000 -> after 2 cycles: s=0, e=11'h07F, lz=0, f={1,0001111,0...}, fl=0000.
REQ-032 db=1, normal=1, operand 64'h0000_0000_0000_0001 -> e=1, lz=52, f=53'h10_0000_0000_0000, fl=0000.
REQ-033 db=1, operand A 64'h7FF0_0000_0000_0001, B 64'h7FF8_0000_0000_0000 -> fla=0011, flb=0010; with UNPACK_NAN_PROP_EN nan=53'h18_0000_0000_0001, without nan=53'h18_0000_0000_0000.
REQ-034 10 back-to-back transactions, out_ready low cycles 4-7 -> in_ready low once both stages full, outputs stable while stalled, all 10 results delivered in order.
REQ-035 rst_n asserted low mid-stream with 2 transactions in flight -> out_valid 0 same cycle, no stale results after release.
REQ-036 db=1, operands +0 and -inf (64'hFFF0_0000_0000_0000) -> fla=1000, lza=53, fa=0; sb=1, flb=0100.
